// File: rtl/frame_pkg.sv
// rtl/frame_pkg.sv - shared types, sizes and check helpers for the frame receiver
package frame_pkg;

    localparam int DATA_BITS  = 8;
    localparam int CNT_BITS   = 4;
    localparam int FRAME_BITS = 15;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        COUNT,
        PARITY,
        STOP
    } state_e;

    // Even parity over the data byte: 1 when an odd number of ones is present
    function automatic logic parity8(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

    // Number of ones in the data byte, 0..8, kept at full count width
    function automatic logic [CNT_BITS-1:0] popcount8(input logic [DATA_BITS-1:0] d);
        logic [CNT_BITS-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_BITS; i++) begin
            c = c + {{(CNT_BITS-1){1'b0}}, d[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/bit_timer.sv
// rtl/bit_timer.sv - per-bit clock counter with mid-bit tick
module bit_timer #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    output logic mid_tick_o
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] MID  = CW'(CLKS_PER_BIT / 2 - 1);

    logic [CW-1:0] cnt_q;

    // Free-running 0..CLKS_PER_BIT-1 counter, held at zero while cleared
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clear_i || cnt_q == LAST) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign mid_tick_o = (cnt_q == MID);

endmodule

// File: rtl/frame_check_rx.sv
// rtl/frame_check_rx.sv - serial frame receiver with parity, count and stop checks
module frame_check_rx
    import frame_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic [CNT_BITS-1:0]  cnt_out,
    output logic                 valid,
    output logic                 par_err,
    output logic                 cnt_err,
    output logic                 frame_err
);

    logic                 rx_meta_q;
    logic                 rx_sync_q;
    state_e               state_q;
    logic [2:0]           bit_idx_q;
    logic [DATA_BITS-1:0] data_sh_q;
    logic [CNT_BITS-1:0]  cnt_sh_q;
    logic                 par_q;
    logic [DATA_BITS-1:0] data_out_q;
    logic [CNT_BITS-1:0]  cnt_out_q;
    logic                 valid_q;
    logic                 par_err_q;
    logic                 cnt_err_q;
    logic                 frame_err_q;
    logic                 mid_tick;

    // Two-flop synchroniser for the asynchronous serial line, idling high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
        end else begin
            rx_meta_q <= rx_in;
            rx_sync_q <= rx_meta_q;
        end
    end

    // Timer is held at zero in IDLE so it starts counting on the falling edge;
    // mid_tick then lands at every bit centre without further re-alignment.
    bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (state_q == IDLE),
        .mid_tick_o(mid_tick)
    );

    // Frame FSM: shifts data and count, captures parity, reports at stop centre
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_idx_q   <= '0;
            data_sh_q   <= '0;
            cnt_sh_q    <= '0;
            par_q       <= 1'b0;
            data_out_q  <= '0;
            cnt_out_q   <= '0;
            valid_q     <= 1'b0;
            par_err_q   <= 1'b0;
            cnt_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            if (state_q != IDLE && !en) begin
                state_q   <= IDLE;
                bit_idx_q <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        bit_idx_q <= '0;
                        // The valid cycle is the first IDLE cycle; a low line there is ignored
                        if (en && !rx_sync_q && !valid_q) begin
                            state_q <= START;
                        end
                    end
                    START: begin
                        if (mid_tick) begin
                            state_q   <= rx_sync_q ? IDLE : DATA;
                            bit_idx_q <= '0;
                        end
                    end
                    DATA: begin
                        if (mid_tick) begin
                            data_sh_q <= {rx_sync_q, data_sh_q[DATA_BITS-1:1]};
                            bit_idx_q <= bit_idx_q + 3'd1;
                            if (bit_idx_q == 3'd7) begin
                                state_q <= COUNT;
                            end
                        end
                    end
                    COUNT: begin
                        if (mid_tick) begin
                            cnt_sh_q  <= {rx_sync_q, cnt_sh_q[CNT_BITS-1:1]};
                            bit_idx_q <= {1'b0, bit_idx_q[1:0] + 2'd1};
                            if (bit_idx_q[1:0] == 2'd3) begin
                                state_q <= PARITY;
                            end
                        end
                    end
                    PARITY: begin
                        if (mid_tick) begin
                            par_q   <= rx_sync_q;
                            state_q <= STOP;
                        end
                    end
                    STOP: begin
                        if (mid_tick) begin
                            data_out_q  <= data_sh_q;
                            cnt_out_q   <= cnt_sh_q;
                            par_err_q   <= par_q != parity8(data_sh_q);
                            cnt_err_q   <= cnt_sh_q != popcount8(data_sh_q);
                            frame_err_q <= !rx_sync_q;
                            valid_q     <= 1'b1;
                            state_q     <= IDLE;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign data_out  = data_out_q;
    assign cnt_out   = cnt_out_q;
    assign valid     = valid_q;
    assign par_err   = par_err_q;
    assign cnt_err   = cnt_err_q;
    assign frame_err = frame_err_q;

endmodule

// File: doc/frame_check_rx.md
FRAME_CHECK_RX -- requirements
Module: frame_check_rx

Interface
REQ-001 The parameter shall be CLKS_PER_BIT, default 4, meaning clock cycles per serial bit (even, >= 2).
REQ-002 The port clk shall be an input, 1 bit wide: the single clock, with all state updated on its rising edge.
REQ-003 The port rst_n shall be an input, 1 bit wide: reset, asynchronous and active-low.
REQ-004 The port en shall be an input, 1 bit wide: receiver enable.
REQ-005 The port rx_in shall be an input, 1 bit wide: serial line, idle high.
REQ-006 The port data_out shall be an output, 8 bits wide: last received data byte.
REQ-007 The port cnt_out shall be an output, 4 bits wide: last received count field.
REQ-008 The port valid shall be an output, 1 bit wide: one-cycle pulse when a frame completes.
REQ-009 The port par_err shall be an output, 1 bit wide: parity mismatch on the last frame.
REQ-010 The port cnt_err shall be an output, 1 bit wide: count-field mismatch on the last frame.
REQ-011 The port frame_err shall be an output, 1 bit wide: stop bit sampled low on the last frame.

Function
REQ-012 The frame shall be, in order: start bit (0), data bits d0..d7 (LSB first), count bits k0..k3 (LSB first), parity bit p, stop bit (1), for 15 bits total.
REQ-013 The state machine shall have the states IDLE, START, DATA, COUNT, PARITY, STOP.
REQ-014 IDLE -> START on the first cycle with en=1 and rx_in=0; the bit-timer shall then load 0.
REQ-015 The bit-timer shall count 0..CLKS_PER_BIT-1 and wrap; each bit shall be sampled when the timer equals CLKS_PER_BIT/2-1 (mid-bit), and the start bit shall be sampled at its mid-point on the same rule.
REQ-016 START: if the mid-bit sample is 1 (glitch), the FSM shall return to IDLE with no outputs changed; if the sample is 0, it shall go to DATA with the timer re-centred so that subsequent samples fall at bit centres.
REQ-017 DATA shall shift in 8 samples (3-bit index, wrap 7 -> COUNT); COUNT shall shift in 4 samples (2-bit index, wrap 3 -> PARITY); PARITY shall take 1 sample -> STOP.
REQ-018 STOP: at the stop-bit mid-sample, the block shall update data_out, cnt_out and the three error flags, and assert valid for exactly the next clock cycle; the FSM shall then go to IDLE.
REQ-019 par_err shall be 1 iff p differs from XOR(d7..d0) (even parity over data).
REQ-020 cnt_err shall be 1 iff the 4-bit count field differs from the popcount of d7..d0 (range 0..8, 4-bit compare, no truncation).
REQ-021 frame_err shall be 1 iff the stop sample is 0; data and the other flags shall still be reported.
REQ-022 Latency shall be: valid high on the cycle after the stop-bit mid-sample, i.e. 14*CLKS_PER_BIT + CLKS_PER_BIT/2 + 1 cycles after the start falling edge is seen in IDLE.
REQ-023 data_out, cnt_out and the error flags shall hold their value until the next valid pulse.
REQ-024 If en drops mid-frame, the block shall abort to IDLE on the next edge, with no valid pulse and outputs unchanged.
REQ-025 rx_in low on the same cycle valid is high shall not start a frame; detection shall resume in IDLE on the following cycle.
REQ-026 rx_in shall be double-flopped before use; the synchroniser delay shall not count toward REQ-022, which is measured at the synchronised signal.

Reset
REQ-027 While rst_n=0, the FSM shall be IDLE, the timer and indices 0, the synchroniser flops 1, data_out=8'h00, cnt_out=4'h0, and valid, par_err, cnt_err and frame_err 0.
REQ-028 Reset asserted mid-frame shall discard the partial frame immediately; after release, the block shall wait in IDLE for a new start bit.

Structure
REQ-029 A shared package frame_pkg shall hold the state enum, DATA_BITS=8, CNT_BITS=4, FRAME_BITS=15 and the parity/popcount helper functions.
REQ-030 One sub-module, bit_timer, shall provide the CLKS_PER_BIT counter with clear input and mid_tick output; the FSM and checks shall stay in frame_check_rx.

Verification (CLKS_PER_BIT=4)
REQ-031 Send data 0xA5, count 4, p=0, stop 1 -> valid pulse after 59 cycles; data_out=A5, cnt_out=4, all errors 0.
REQ-032 Send data 0xFF, count 7, p=0, stop 1 -> cnt_out=7, cnt_err=1, par_err=0, frame_err=0.
REQ-033 Send data 0x01, count 1, p=0, stop 0 -> par_err=1, frame_err=1, cnt_err=0, data_out=01.
REQ-034 Drive rx_in low for 1 cycle in IDLE -> no valid, FSM back in IDLE, outputs unchanged.
REQ-035 Pulse rst_n low during DATA bit 3, then send a full 0x3C frame (count 4, p=0) -> exactly one valid, with data_out=3C.
REQ-036 Drop en during COUNT -> no valid; re-enable and send 0x80 (count 1, p=1) -> valid with data_out=80 and no errors.
